// File: rtl/param_stack_if.sv
// param_stack_if: operation/result bundle between a stack user (master) and param_stack (slave).
interface param_stack_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
);
   logic [2:0]               i_op;
   logic [WIDTH-1:0]         i_data;
   logic                     i_clr_err;
   logic [WIDTH-1:0]         o_top;
   logic [WIDTH-1:0]         o_next;
   logic [$clog2(DEPTH):0]   o_depth;
   logic                     o_empty;
   logic                     o_full;
   logic                     o_overflow;
   logic                     o_underflow;
   modport master (
      output i_op, i_data, i_clr_err,
      input  o_top, o_next, o_depth, o_empty, o_full, o_overflow, o_underflow
   );
   modport slave (
      input  i_op, i_data, i_clr_err,
      output o_top, o_next, o_depth, o_empty, o_full, o_overflow, o_underflow
   );
endinterface

// File: rtl/param_stack.sv
// param_stack: single-cycle operand stack; top/next live in registers, deeper entries in an array.
// Define PARAM_STACK_SWAP_EN to enable SWAP/OVER; otherwise those opcodes are NOPs.
module param_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input logic          i_clock,
   input logic          i_reset_n,
   param_stack_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [DW-1:0] FULL_DEPTH = DW'(DEPTH);

   typedef enum logic [2:0] {
      OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_DUP, OP_SWAP, OP_OVER, OP_CLEAR
   } opCode_t;

   opCode_t          op;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] topReg, nextReg, nTop, nNext;
   logic [DW-1:0]    depthReg, nDepth;
   logic             emptyReg, fullReg, ovfReg, udfReg;
   logic             memWe, ovfSet, udfSet, isEmpty, isFull, atLeast2, atLeast3;
   logic [AW-1:0]    wrIdx, rdIdx;

   assign op       = opCode_t'(bus.i_op);
   assign isEmpty  = depthReg == '0;
   assign isFull   = depthReg == FULL_DEPTH;
   assign atLeast2 = depthReg >= DW'(2);
   assign atLeast3 = depthReg >= DW'(3);
   // The array holds entries beneath next: slot depth-2 is where next spills on a grow.
   assign wrIdx    = AW'(depthReg - DW'(2));
   assign rdIdx    = AW'(depthReg - DW'(3));

   always_comb begin
      nTop   = topReg;
      nNext  = nextReg;
      nDepth = depthReg;
      memWe  = 1'b0;
      ovfSet = 1'b0;
      udfSet = 1'b0;
      case (op)
         OP_PUSH: begin
            if (isFull) ovfSet = 1'b1;
            else begin
               memWe  = atLeast2;
               nNext  = topReg;
               nTop   = bus.i_data;
               nDepth = depthReg + 1'b1;
            end
         end
         OP_POP: begin
            if (isEmpty) udfSet = 1'b1;
            else begin
               nTop   = nextReg;
               nNext  = atLeast3 ? mem[rdIdx] : '0;
               nDepth = depthReg - 1'b1;
            end
         end
         OP_REPLACE: begin
            if (isEmpty) udfSet = 1'b1;
            else nTop = bus.i_data;
         end
         OP_DUP: begin
            if (isEmpty) udfSet = 1'b1;
            else if (isFull) ovfSet = 1'b1;
            else begin
               memWe  = atLeast2;
               nNext  = topReg;
               nDepth = depthReg + 1'b1;
            end
         end
`ifdef PARAM_STACK_SWAP_EN
         OP_SWAP: begin
            if (!atLeast2) udfSet = 1'b1;
            else begin
               nTop  = nextReg;
               nNext = topReg;
            end
         end
         OP_OVER: begin
            if (!atLeast2) udfSet = 1'b1;
            else if (isFull) ovfSet = 1'b1;
            else begin
               memWe  = 1'b1;
               nNext  = topReg;
               nTop   = nextReg;
               nDepth = depthReg + 1'b1;
            end
         end
`endif
         OP_CLEAR: begin
            nTop   = '0;
            nNext  = '0;
            nDepth = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         topReg   <= '0;
         nextReg  <= '0;
         depthReg <= '0;
         emptyReg <= 1'b1;
         fullReg  <= 1'b0;
         ovfReg   <= 1'b0;
         udfReg   <= 1'b0;
      end else begin
         topReg   <= nTop;
         nextReg  <= nNext;
         depthReg <= nDepth;
         emptyReg <= nDepth == '0;
         fullReg  <= nDepth == FULL_DEPTH;
         ovfReg   <= ovfSet | (ovfReg & ~bus.i_clr_err);
         udfReg   <= udfSet | (udfReg & ~bus.i_clr_err);
      end
   end

   always_ff @(posedge i_clock) begin
      if (memWe) mem[wrIdx] <= nextReg;
   end

   assign bus.o_top       = topReg;
   assign bus.o_next      = nextReg;
   assign bus.o_depth     = depthReg;
   assign bus.o_empty     = emptyReg;
   assign bus.o_full      = fullReg;
   assign bus.o_overflow  = ovfReg;
   assign bus.o_underflow = udfReg;
endmodule
